// File: rtl/vedic2b_mul.sv
// vedic2b_mul: 2x2-bit unsigned Vedic (Urdhva-Tiryakbhyam) multiplier leaf cell.
// The product o is purely combinational. o_q is a 1-cycle registered copy for
// pipelined parents.
// Optional build macro VEDIC2BMUL_SELFCHECK_EN adds a sticky err output. It goes
// high when o disagrees with a behavioural reference product at a clock edge.
// Interface: no handshake. o_q follows o on every rising clk edge while rst_n=1.
module vedic2b_mul #(
  parameter logic [3:0] OQ_RST_VAL = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] o,
  output logic [3:0] o_q
`ifdef VEDIC2BMUL_SELFCHECK_EN
  ,
  output logic       err
`endif
);

  // Vertical/crosswise partial products
  logic p00;
  logic p01;
  logic p10;
  logic p11;
  logic c1;
  logic [3:0] prod_d;
  logic [3:0] oq_q;

  assign p00 = a[0] & b[0];
  assign p01 = a[0] & b[1];
  assign p10 = a[1] & b[0];
  assign p11 = a[1] & b[1];

  // Half adders: the crosswise column feeds its carry into the top vertical column
  always_comb begin
    prod_d    = 4'h0;
    c1        = p10 & p01;
    prod_d[0] = p00;
    prod_d[1] = p10 ^ p01;
    prod_d[2] = p11 ^ c1;
    prod_d[3] = p11 & c1;
  end

  assign o   = prod_d;
  assign o_q = oq_q;

  // Registered product copy, asynchronously forced to OQ_RST_VAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oq_q <= OQ_RST_VAL;
    end else begin
      oq_q <= prod_d;
    end
  end

`ifdef VEDIC2BMUL_SELFCHECK_EN
  logic [3:0] ref_prod;
  logic       err_q;

  assign ref_prod = {2'b00, a} * {2'b00, b};
  assign err      = err_q;

  // Sticky mismatch flag between the gate-level product and the reference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (prod_d !== ref_prod) begin
      err_q <= 1'b1;
`ifndef SYNTHESIS
      $error("vedic2b_mul self-check: a=%0d b=%0d o=%0d ref=%0d", a, b, prod_d, ref_prod);
`endif
    end
  end
`endif

endmodule

// File: tb/tb_vedic2b_mul.sv
// tb_vedic2b_mul: table-driven and randomized bench for vedic2b_mul.
// Expected products come from plain integer multiplication of the inputs.
module tb_vedic2b_mul;

  localparam logic [3:0] RST_VAL = 4'h0;

  logic       clk;
  logic       rst_n;
  logic [1:0] a;
  logic [1:0] b;
  logic [3:0] o;
  logic [3:0] o_q;
`ifdef VEDIC2BMUL_SELFCHECK_EN
  logic       err;
`endif

  int n_vec;
  int n_err;

  logic [3:0] exp_q[$];

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] exp_o;
  } vec_t;

  vec_t vecs[$];

  vedic2b_mul #(.OQ_RST_VAL(RST_VAL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .o     (o),
    .o_q   (o_q)
`ifdef VEDIC2BMUL_SELFCHECK_EN
    ,
    .err   (err)
`endif
  );

  // Clock: 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain unsigned arithmetic
  function automatic logic [3:0] model_mul(input logic [1:0] x, input logic [1:0] y);
    int r;
    r = int'(x) * int'(y);
    return r[3:0];
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d (%b) expected %0d (%b)", name, act, act, exp_v, exp_v);
    end
  endtask

  task automatic drive(input logic [1:0] x, input logic [1:0] y);
    @(negedge clk);
    a = x;
    b = y;
  endtask

  initial begin
    logic [1:0] ra;
    logic [1:0] rb;
    n_vec = 0;
    n_err = 0;

    // Reset asserted before any clock edge: o_q already at reset value
    rst_n = 1'b0;
    a = 2'd3;
    b = 2'd3;
    #1;
    check("reset_oq_no_clk", o_q, RST_VAL);
    check("reset_o_unaffected", o, 4'd9);

    // Spec corner cases with literal expectations
    vecs.push_back('{a: 2'd0, b: 2'd3, exp_o: 4'd0});
    vecs.push_back('{a: 2'd3, b: 2'd0, exp_o: 4'd0});
    vecs.push_back('{a: 2'd3, b: 2'd1, exp_o: 4'd3});
    vecs.push_back('{a: 2'd3, b: 2'd2, exp_o: 4'd6});
    vecs.push_back('{a: 2'd2, b: 2'd3, exp_o: 4'd6});
    vecs.push_back('{a: 2'd3, b: 2'd3, exp_o: 4'd9});
    vecs.push_back('{a: 2'd2, b: 2'd2, exp_o: 4'd4});
    vecs.push_back('{a: 2'd1, b: 2'd1, exp_o: 4'd1});
    // Exhaustive sweep from the model
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        vecs.push_back('{a: 2'(i), b: 2'(j), exp_o: model_mul(2'(i), 2'(j))});
      end
    end

    for (int k = 0; k < vecs.size(); k++) begin
      a = vecs[k].a;
      b = vecs[k].b;
      #1;
      check($sformatf("comb_%0dx%0d", vecs[k].a, vecs[k].b), o, vecs[k].exp_o);
    end

    // Still in reset after clock edges: o_q held
    repeat (2) @(posedge clk);
    #1;
    check("reset_oq_held", o_q, RST_VAL);

    // Release reset, drive 2*3: o_q updates only at the next rising edge
    drive(2'd0, 2'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("oq_first_edge_0", o_q, 4'd0);
    drive(2'd2, 2'd3);
    #1;
    check("comb_2x3_live", o, 4'd6);
    check("oq_before_edge", o_q, 4'd0);
    @(posedge clk);
    #1;
    check("oq_after_edge", o_q, 4'd6);

    // Mid-cycle reset: o_q clears at once, o keeps showing 6
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_oq", o_q, RST_VAL);
    check("midrun_reset_o", o, 4'd6);
    @(posedge clk);
    #1;
    check("midrun_reset_oq_hold", o_q, RST_VAL);
`ifdef VEDIC2BMUL_SELFCHECK_EN
    check("err_reset", {3'b000, err}, 4'd0);
`endif
    drive(2'd1, 2'd3);
    rst_n = 1'b1;

    // Random: combinational and registered paths against the model
    for (int it = 0; it < 100; it++) begin
      ra = 2'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 3));
      drive(ra, rb);
      #1;
      check($sformatf("rand_o_%0d", it), o, model_mul(ra, rb));
      exp_q.push_back(model_mul(ra, rb));
      @(posedge clk);
      #1;
      check($sformatf("rand_oq_%0d", it), o_q, exp_q.pop_front());
    end

    // Back-to-back registered sequence: each edge captures the value driven before it
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        drive(2'(i), 2'(j));
        exp_q.push_back(model_mul(2'(i), 2'(j)));
        @(posedge clk);
        #1;
        check($sformatf("seq_oq_%0dx%0d", i, j), o_q, exp_q.pop_front());
      end
    end

`ifdef VEDIC2BMUL_SELFCHECK_EN
    check("err_after_sweep", {3'b000, err}, 4'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
